// File: rtl/uart_receptor_pkg.sv
// Shared types and default sizing for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } estado_t;

    // 50 MHz clock, 9180 ns bit time
    localparam int CLKS_PER_BIT_DEF = 459;
    localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_receptor_detector_flanco.sv
// Two-flop synchroniser for the asynchronous RX line plus a falling-edge
// detector on the synchronised sample. All flops reset to 1 (idle line), so
// releasing reset never looks like a start bit.
module detector_flanco (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_x,
    output logic o_x_s,
    output logic o_flanco
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronise x into clk domain and keep the previous synchronised sample
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_x;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_x_s    = r_sync2;
    assign o_flanco = r_prev & ~r_sync2;

endmodule

// File: rtl/uart_receptor.sv
// 8N1 UART receiver. Start bit is qualified at its middle, data bits are
// sampled at their middles LSB-first, and the stop bit decides between a
// valid byte (dato_listo) and a framing error (error_trama).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line idle; waiting for an enabled high-to-low transition
//   START | timing half a bit to the start-bit middle, rejecting glitches
//   DATA  | sampling one data bit every CLKS_PER_BIT cycles
//   STOP  | timing to the stop-bit middle, then flag byte or error
module uart_receptor
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 deteccion_flanco_bajada,
    input  logic                 x,
    output logic [DATA_BITS-1:0] dato,
    output logic                 dato_listo,
    output logic                 error_trama,
    output logic                 ocupado
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Tick timer is a down-counter; these are its load values
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic w_x_s;
    logic w_flanco;

    estado_t              r_estado;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dato;
    logic                 r_listo;
    logic                 r_error;

    detector_flanco u_detector (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_x      (x),
        .o_x_s    (w_x_s),
        .o_flanco (w_flanco)
    );

    // Receive FSM: bit timing, deserialisation and one-cycle result pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_dato   <= '0;
            r_listo  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_listo <= 1'b0;
            r_error <= 1'b0;
            case (r_estado)
                IDLE: begin
                    // Edges while disabled are dropped, not remembered
                    if (deteccion_flanco_bajada && w_flanco) begin
                        r_estado <= START;
                        r_tick   <= HALF_M1;
                        r_bit    <= '0;
                    end
                end
                START: begin
                    if (r_tick == '0) begin
                        if (!w_x_s) begin
                            r_estado <= DATA;
                            r_tick   <= FULL_M1;
                        end else begin
                            r_estado <= IDLE;
                        end
                    end else begin
                        r_tick <= r_tick - 1'b1;
                    end
                end
                DATA: begin
                    if (r_tick == '0) begin
                        r_tick  <= FULL_M1;
                        r_shift <= {w_x_s, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == LAST_BIT) begin
                            r_estado <= STOP;
                        end
                    end else begin
                        r_tick <= r_tick - 1'b1;
                    end
                end
                STOP: begin
                    if (r_tick == '0) begin
                        if (w_x_s) begin
                            r_dato  <= r_shift;
                            r_listo <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_estado <= IDLE;
                    end else begin
                        r_tick <= r_tick - 1'b1;
                    end
                end
                default: r_estado <= IDLE;
            endcase
        end
    end

    assign dato        = r_dato;
    assign dato_listo  = r_listo;
    assign error_trama = r_error;
    assign ocupado     = (r_estado != IDLE);

endmodule

// File: tb/tb_uart_receptor.sv
// Directed bench for uart_receptor at 50 MHz / 9180 ns bit time.
module tb_uart_receptor;

    localparam int BIT_NS = 9180;

    logic       clk;
    logic       reset;
    logic       deteccion_flanco_bajada;
    logic       x;
    logic [7:0] dato;
    logic       dato_listo;
    logic       error_trama;
    logic       ocupado;

    int n_checks = 0;
    int n_errors = 0;

    int  n_listo_cyc  = 0;
    int  n_listo_rise = 0;
    int  n_err_cyc    = 0;
    int  n_both       = 0;
    int  n_busy       = 0;
    logic prev_listo  = 1'b0;

    uart_receptor #(
        .CLKS_PER_BIT (459),
        .DATA_BITS    (8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .deteccion_flanco_bajada (deteccion_flanco_bajada),
        .x                       (x),
        .dato                    (dato),
        .dato_listo              (dato_listo),
        .error_trama             (error_trama),
        .ocupado                 (ocupado)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse/activity monitor sampled away from the active edge
    always @(negedge clk) begin
        if (dato_listo) n_listo_cyc++;
        if (dato_listo && !prev_listo) n_listo_rise++;
        if (error_trama) n_err_cyc++;
        if (dato_listo && error_trama) n_both++;
        if (ocupado) n_busy++;
        prev_listo = dato_listo;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB-first, one stop bit of the given value
    task automatic send_frame(input logic [7:0] d, input logic stop);
        x = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            x = d[i];
            #(BIT_NS);
        end
        x = stop;
        #(BIT_NS);
    endtask

    int base_listo;
    int base_err;
    int base_busy;

    initial begin
        reset = 1'b1;
        x = 1'b1;
        deteccion_flanco_bajada = 1'b1;
        #11;
        check("rst_dato",  dato, 8'h00);
        check("rst_listo", dato_listo, 1'b0);
        check("rst_err",   error_trama, 1'b0);
        check("rst_busy",  ocupado, 1'b0);
        #11;
        reset = 1'b0;
        #2000;
        check("idle_busy",  n_busy, 0);
        check("idle_listo", n_listo_cyc, 0);

        // Framing error, then line held low (break) must not retrigger
        send_frame(8'h03, 1'b0);
        #(2 * BIT_NS);
        check("ferr_err",   n_err_cyc, 1);
        check("ferr_listo", n_listo_cyc, 0);
        check("ferr_dato",  dato, 8'h00);
        check("ferr_busy",  ocupado, 1'b0);
        x = 1'b1;
        #(BIT_NS);
        check("ferr_break_err", n_err_cyc, 1);

        // Clean 0x55
        send_frame(8'h55, 1'b1);
        #200;
        check("f55_dato",  dato, 8'h55);
        check("f55_cyc",   n_listo_cyc, 1);
        check("f55_rise",  n_listo_rise, 1);
        check("f55_busy",  ocupado, 1'b0);

        // Back-to-back 0xA3, 0x0F
        send_frame(8'hA3, 1'b1);
        check("b2b_first", dato, 8'hA3);
        send_frame(8'h0F, 1'b1);
        #200;
        check("b2b_second", dato, 8'h0F);
        check("b2b_cyc",    n_listo_cyc, 3);
        check("b2b_rise",   n_listo_rise, 3);

        // Short low glitch: false start
        base_listo = n_listo_cyc;
        base_err   = n_err_cyc;
        x = 1'b0;
        #1000;
        check("gl_busy_during", ocupado, 1'b1);
        #1000;
        x = 1'b1;
        #4000;
        check("gl_busy_after", ocupado, 1'b0);
        #(BIT_NS);
        check("gl_listo", n_listo_cyc, base_listo);
        check("gl_err",   n_err_cyc, base_err);

        // Detection disabled: whole frame ignored
        deteccion_flanco_bajada = 1'b0;
        base_busy = n_busy;
        send_frame(8'h55, 1'b1);
        #(BIT_NS);
        check("dis_busy",  n_busy, base_busy);
        check("dis_listo", n_listo_cyc, base_listo);
        check("dis_dato",  dato, 8'h0F);
        deteccion_flanco_bajada = 1'b1;

        // Reset during data bit 4
        x = 1'b0;
        #(BIT_NS);
        x = 1'b1; #(BIT_NS);
        x = 1'b0; #(BIT_NS);
        x = 1'b1; #(BIT_NS);
        x = 1'b1; #(BIT_NS);
        x = 1'b0;
        #4000;
        check("rmid_busy_before", ocupado, 1'b1);
        reset = 1'b1;
        #1;
        check("rmid_busy",  ocupado, 1'b0);
        check("rmid_dato",  dato, 8'h00);
        check("rmid_listo", dato_listo, 1'b0);
        #100;
        x = 1'b1;
        #100;
        reset = 1'b0;
        #(4 * BIT_NS);
        check("rmid_nopulse_l", n_listo_cyc, base_listo);
        check("rmid_nopulse_e", n_err_cyc, base_err);

        // Recovery frame
        send_frame(8'hC6, 1'b1);
        #200;
        check("rec_dato",  dato, 8'hC6);
        check("rec_cyc",   n_listo_cyc, base_listo + 1);
        check("rec_busy",  ocupado, 1'b0);

        check("never_both", n_both, 0);
        check("pulse_width", n_listo_cyc, n_listo_rise);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
